// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: CSR address map, funct3 encodings, FSM states
// and the address-decode helpers used by the CSR access unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_TIME    = 12'hC01;
  localparam logic [11:0] CSR_TIMEH   = 12'hC81;
  localparam logic [11:0] CSR_VSTART  = 12'h008;
  localparam logic [11:0] CSR_VXSAT   = 12'h009;
  localparam logic [11:0] CSR_VXRM    = 12'h00A;
  localparam logic [11:0] CSR_VCSR    = 12'h00F;
  localparam logic [11:0] CSR_VL      = 12'hC20;
  localparam logic [11:0] CSR_VTYPE   = 12'hC21;
  localparam logic [11:0] CSR_VLENB   = 12'hC22;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

  typedef enum logic [2:0] {
    CSR_OP_ILL0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_ILL4 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  typedef enum logic [2:0] {
    CSR_IDLE  = 3'd0,
    CSR_READ  = 3'd1,
    CSR_WRITE = 3'd2,
    CSR_RESP  = 3'd3,
    CSR_EXC   = 3'd4
  } csr_state_e;

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MIP, CSR_MCYCLE, CSR_TIME, CSR_TIMEH, CSR_VSTART, CSR_VXSAT,
      CSR_VXRM, CSR_VCSR, CSR_VL, CSR_VTYPE, CSR_VLENB:
        csr_is_implemented = 1'b1;
      default:
        csr_is_implemented = 1'b0;
    endcase
  endfunction

  // Privileged-spec convention: address bits [11:10] == 2'b11 mark read-only CSRs.
  function automatic logic csr_is_readonly(input logic [11:0] addr);
    csr_is_readonly = (addr[11:10] == 2'b11);
  endfunction

  function automatic logic csr_op_is_valid(input csr_op_e op);
    csr_op_is_valid = (op != CSR_OP_ILL0) && (op != CSR_OP_ILL4);
  endfunction

  function automatic logic csr_op_is_write(input csr_op_e op);
    csr_op_is_write = (op == CSR_OP_RW) || (op == CSR_OP_RWI);
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundles the request, CSR-file, writeback and trap signals of the CSR access unit.
interface csr_access_unit_if #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_IDX_WIDTH = 5
);
  logic                     req_valid;
  logic                     req_ready;
  logic [2:0]               req_op;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_rs1_data;
  logic [REG_IDX_WIDTH-1:0] req_rs1_idx;
  logic [REG_IDX_WIDTH-1:0] req_rd;
  logic [31:0]              req_pc;
  logic                     flush;

  logic                     csr_read_en;
  logic [ADDR_WIDTH-1:0]    csr_read_addr;
  logic [DATA_WIDTH-1:0]    csr_read_data;
  logic                     csr_write_en;
  logic [ADDR_WIDTH-1:0]    csr_write_addr;
  logic [DATA_WIDTH-1:0]    csr_write_data;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [REG_IDX_WIDTH-1:0] rsp_rd;
  logic                     rsp_we;
  logic [DATA_WIDTH-1:0]    rsp_data;

  logic                     exc_valid;
  logic [3:0]               exc_code;
  logic [31:0]              exc_pc;
  logic [31:0]              exc_tval;

  logic                     busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_rs1_data, req_rs1_idx, req_rd,
           req_pc, flush, csr_read_data, rsp_ready,
    output req_ready, csr_read_en, csr_read_addr, csr_write_en,
           csr_write_addr, csr_write_data, rsp_valid, rsp_rd, rsp_we,
           rsp_data, exc_valid, exc_code, exc_pc, exc_tval, busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_rs1_data, req_rs1_idx, req_rd,
           req_pc, flush, csr_read_data, rsp_ready,
    input  req_ready, csr_read_en, csr_read_addr, csr_write_en,
           csr_write_addr, csr_write_data, rsp_valid, rsp_rd, rsp_we,
           rsp_data, exc_valid, exc_code, exc_pc, exc_tval, busy
  );

endinterface

// File: rtl/csr_alu.sv
// Combinational merge of the old CSR value with the source operand
// for the write (RW), set (RS) and clear (RC) CSR instructions.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  csr_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_src,
  output logic [DATA_WIDTH-1:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (i_op)
      CSR_OP_RW, CSR_OP_RWI: o_new = i_src;
      CSR_OP_RS, CSR_OP_RSI: o_new = i_old | i_src;
      CSR_OP_RC, CSR_OP_RCI: o_new = i_old & ~i_src;
      default:               o_new = i_old;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execute stage: registers a decoded CSR request, reads the CSR file,
// writes the merged value back, then returns the old value or raises a trap.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_IDX_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  csr_access_unit_if.slave   bus
);

  csr_state_e               r_state;
  csr_op_e                  r_op;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_src;
  logic [REG_IDX_WIDTH-1:0] r_rd;
  logic [31:0]              r_pc;
  logic                     r_wr_intent;
  logic                     r_rd_intent;
  logic                     r_illegal;
  logic [DATA_WIDTH-1:0]    r_old;
  logic [DATA_WIDTH-1:0]    r_new;

  csr_op_e                  w_op;
  logic                     w_accept;
  logic [DATA_WIDTH-1:0]    w_src;
  logic                     w_wr_intent;
  logic                     w_rd_intent;
  logic                     w_illegal;
  logic [DATA_WIDTH-1:0]    w_old;
  logic [DATA_WIDTH-1:0]    w_new;

  // Request decode; intents and legality are resolved at acceptance so the
  // READ cycle only needs registered state.
  always_comb begin
    w_op        = csr_op_e'(bus.req_op);
    w_src       = bus.req_op[2] ? DATA_WIDTH'(bus.req_rs1_idx) : bus.req_rs1_data;
    w_wr_intent = csr_op_is_write(w_op) || (bus.req_rs1_idx != '0);
    w_rd_intent = !(csr_op_is_write(w_op) && (bus.req_rd == '0));
    w_illegal   = !csr_op_is_valid(w_op)
               || !csr_is_implemented(12'(bus.req_addr))
               || (w_wr_intent && csr_is_readonly(12'(bus.req_addr)));
  end

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_old    = r_rd_intent ? bus.csr_read_data : '0;

  csr_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_op  (r_op),
    .i_old (w_old),
    .i_src (r_src),
    .o_new (w_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CSR_IDLE;
      r_op        <= CSR_OP_ILL0;
      r_addr      <= '0;
      r_src       <= '0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_wr_intent <= 1'b0;
      r_rd_intent <= 1'b0;
      r_illegal   <= 1'b0;
      r_old       <= '0;
      r_new       <= '0;
    end else if (bus.flush) begin
      r_state <= CSR_IDLE;
    end else begin
      case (r_state)
        CSR_IDLE: begin
          if (w_accept) begin
            r_op        <= w_op;
            r_addr      <= bus.req_addr;
            r_src       <= w_src;
            r_rd        <= bus.req_rd;
            r_pc        <= bus.req_pc;
            r_wr_intent <= w_wr_intent;
            r_rd_intent <= w_rd_intent;
            r_illegal   <= w_illegal;
            r_state     <= CSR_READ;
          end
        end
        CSR_READ: begin
          r_old   <= w_old;
          r_new   <= w_new;
          r_state <= r_illegal ? CSR_EXC : CSR_WRITE;
        end
        CSR_WRITE: r_state <= CSR_RESP;
        CSR_RESP:  if (bus.rsp_ready) r_state <= CSR_IDLE;
        CSR_EXC:   r_state <= CSR_IDLE;
        default:   r_state <= CSR_IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is high, even before the state register
  // has been cleared; flush masks the side-effecting strobes in the same cycle.
  always_comb begin
    bus.req_ready      = (r_state == CSR_IDLE) && !bus.flush && !rst;
    bus.busy           = (r_state != CSR_IDLE) && !rst;
    bus.csr_read_en    = 1'b0;
    bus.csr_read_addr  = '0;
    bus.csr_write_en   = 1'b0;
    bus.csr_write_addr = '0;
    bus.csr_write_data = '0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_rd         = '0;
    bus.rsp_we         = 1'b0;
    bus.rsp_data       = '0;
    bus.exc_valid      = 1'b0;
    bus.exc_code       = '0;
    bus.exc_pc         = '0;
    bus.exc_tval       = '0;
    if (!rst) begin
      case (r_state)
        CSR_READ: begin
          bus.csr_read_en   = r_rd_intent;
          bus.csr_read_addr = r_addr;
        end
        CSR_WRITE: begin
          bus.csr_write_en   = r_wr_intent && !bus.flush;
          bus.csr_write_addr = r_addr;
          bus.csr_write_data = r_new;
        end
        CSR_RESP: begin
          bus.rsp_valid = !bus.flush;
          bus.rsp_rd    = r_rd;
          bus.rsp_we    = (r_rd != '0);
          bus.rsp_data  = r_old;
        end
        CSR_EXC: begin
          bus.exc_valid = !bus.flush;
          bus.exc_code  = EXC_ILLEGAL_INSTR;
          bus.exc_pc    = r_pc;
          bus.exc_tval  = 32'(r_addr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed Zicsr scenarios plus randomized ops
// compared against a shadow CSR model built from the instruction semantics.
module tb_csr_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .REG_IDX_WIDTH(5)) bus ();

  csr_access_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .REG_IDX_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bench-side CSR register file and the independent shadow model
  logic [31:0] csr_file [4096];
  logic [31:0] ref_csr  [4096];
  assign bus.csr_read_data = csr_file[bus.csr_read_addr];

  logic [11:0] impl_list   [17] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343,
                                    12'h344, 12'hB00, 12'hC01, 12'hC81, 12'h008, 12'h009,
                                    12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22};
  logic [11:0] unimpl_list [3]  = '{12'h7FF, 12'h301, 12'hC00};

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last transaction
  int          o_rd_en_cnt, o_wr_cnt, o_wr_cyc, o_exc_cnt, o_exc_cyc;
  int          o_rsp_cyc, o_rsp_cnt, o_idle_cyc;
  logic [11:0] o_wr_addr;
  logic [31:0] o_wr_data, o_rsp_data, o_exc_pc, o_exc_tval;
  logic [3:0]  o_exc_code;
  logic [4:0]  o_rsp_rd;
  logic        o_rsp_we, o_rsp_unstable, o_ready_in_rsp, o_idle_ready, o_idle_rsp;
  logic        o_rst_zero, o_timeout;

  // Model outputs
  logic        m_ill, m_wr, m_rdn;
  logic [31:0] m_old, m_new;

  task automatic model(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1d,
                       input logic [4:0] idx, input logic [4:0] rd);
    logic        impl;
    logic [31:0] src;
    int          kind;
    kind = int'(op) % 4;
    impl = 1'b0;
    foreach (impl_list[i]) if (impl_list[i] == addr) impl = 1'b1;
    src   = (op >= 3'd4) ? {27'd0, idx} : rs1d;
    m_wr  = (kind == 1) || (idx != 5'd0);
    m_rdn = !((kind == 1) && (rd == 5'd0));
    m_ill = (kind == 0) || !impl || (m_wr && addr >= 12'hC00);
    m_old = m_rdn ? ref_csr[addr] : 32'd0;
    case (kind)
      1:       m_new = src;
      2:       m_new = m_old | src;
      default: m_new = m_old & ~src;
    endcase
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] val);
    csr_file[addr] = val;
    ref_csr[addr]  = val;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1d,
                        input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] pc,
                        input int hold, input int flush_at, input int rst_at);
    int n;
    int held;
    o_rd_en_cnt = 0; o_wr_cnt = 0; o_wr_cyc = 0; o_exc_cnt = 0; o_exc_cyc = 0;
    o_rsp_cyc = 0; o_rsp_cnt = 0; o_idle_cyc = 0; o_wr_addr = '0; o_wr_data = '0;
    o_rsp_data = '0; o_exc_pc = '0; o_exc_tval = '0; o_exc_code = '0; o_rsp_rd = '0;
    o_rsp_we = 0; o_rsp_unstable = 0; o_ready_in_rsp = 0; o_idle_ready = 0; o_idle_rsp = 0;
    o_rst_zero = 0; o_timeout = 0; held = 0;
    @(negedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_rs1_data = rs1d;
    bus.req_rs1_idx = idx; bus.req_rd = rd; bus.req_pc = pc;
    n = 0;
    while (!bus.req_ready && n < 10) begin @(negedge clk); #1; n++; end
    if (!bus.req_ready) o_timeout = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.flush = (k == flush_at);
      rst       = (k == rst_at);
      #1;
      if (bus.csr_read_en) o_rd_en_cnt++;
      if (bus.csr_write_en) begin
        o_wr_cnt++; o_wr_cyc = k; o_wr_addr = bus.csr_write_addr; o_wr_data = bus.csr_write_data;
        csr_file[bus.csr_write_addr] = bus.csr_write_data;
      end
      if (bus.exc_valid) begin
        o_exc_cnt++; o_exc_cyc = k; o_exc_code = bus.exc_code; o_exc_pc = bus.exc_pc;
        o_exc_tval = bus.exc_tval;
      end
      if (bus.rsp_valid) begin
        o_rsp_cnt++;
        if (o_rsp_cyc == 0) begin
          o_rsp_cyc = k; o_rsp_rd = bus.rsp_rd; o_rsp_we = bus.rsp_we; o_rsp_data = bus.rsp_data;
        end else if (bus.rsp_rd !== o_rsp_rd || bus.rsp_we !== o_rsp_we || bus.rsp_data !== o_rsp_data)
          o_rsp_unstable = 1'b1;
        if (bus.req_ready) o_ready_in_rsp = 1'b1;
        if (held >= hold) bus.rsp_ready = 1'b1;
        else held++;
      end
      if (rst) begin
        o_rst_zero = !bus.req_ready && !bus.busy && !bus.rsp_valid && !bus.rsp_we &&
                     !bus.exc_valid && !bus.csr_read_en && !bus.csr_write_en &&
                     bus.rsp_data == 32'd0 && bus.exc_code == 4'd0 && bus.csr_write_data == 32'd0;
      end else if (!bus.busy) begin
        o_idle_cyc = k; o_idle_ready = bus.req_ready; o_idle_rsp = bus.rsp_valid;
        break;
      end
    end
    bus.flush = 1'b0; rst = 1'b0; bus.rsp_ready = 1'b0;
    if (o_idle_cyc == 0) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_addr = 12'h300;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.exc_valid !== 1'b0 ||
        bus.csr_read_en !== 1'b0 || bus.csr_write_en !== 1'b0 || bus.rsp_data !== 32'd0 || bus.exc_code !== 4'd0)
      begin n_fail++; $display("FAIL reset_outputs: got ready=%b busy=%b rsp=%b exc=%b rd=%b wr=%b, expected all 0",
        bus.req_ready, bus.busy, bus.rsp_valid, bus.exc_valid, bus.csr_read_en, bus.csr_write_en); end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_release: got ready=%b busy=%b, expected ready=1 busy=0", bus.req_ready, bus.busy); end
  endtask

  task automatic test_csrrw();
    preload(12'h305, 32'd0);
    run_op(3'b001, 12'h305, 32'h8000_0100, 5'd9, 5'd5, 32'h0000_1000, 0, 0, 0);
    n_checks++;
    if (o_wr_cnt !== 1 || o_wr_cyc !== 2 || o_wr_addr !== 12'h305 || o_wr_data !== 32'h8000_0100)
      begin n_fail++; $display("FAIL rw_write: got cnt=%0d cyc=%0d addr=%h data=%h, expected 1 2 305 80000100",
        o_wr_cnt, o_wr_cyc, o_wr_addr, o_wr_data); end
    n_checks++;
    if (o_rsp_cyc !== 3 || o_rsp_rd !== 5'd5 || o_rsp_we !== 1'b1 || o_rsp_data !== 32'd0 || o_exc_cnt !== 0)
      begin n_fail++; $display("FAIL rw_rsp: got cyc=%0d rd=%0d we=%b data=%h exc=%0d, expected 3 5 1 0 0",
        o_rsp_cyc, o_rsp_rd, o_rsp_we, o_rsp_data, o_exc_cnt); end
  endtask

  task automatic test_csrrs();
    preload(12'h300, 32'h1800);
    run_op(3'b010, 12'h300, 32'h8, 5'd3, 5'd7, 32'h0000_1004, 0, 0, 0);
    n_checks++;
    if (o_wr_cnt !== 1 || o_wr_cyc !== 2 || o_wr_data !== 32'h1808)
      begin n_fail++; $display("FAIL rs_write: got cnt=%0d cyc=%0d data=%h, expected 1 2 00001808", o_wr_cnt, o_wr_cyc, o_wr_data); end
    n_checks++;
    if (o_rsp_data !== 32'h1800 || o_rsp_cyc !== 3)
      begin n_fail++; $display("FAIL rs_rsp: got data=%h cyc=%0d, expected 00001800 3", o_rsp_data, o_rsp_cyc); end
  endtask

  task automatic test_no_side_effect();
    preload(12'h304, 32'h880);
    run_op(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd0, 5'd4, 32'h0000_1008, 0, 0, 0);
    n_checks++;
    if (o_wr_cnt !== 0 || o_rsp_data !== 32'h880 || o_rsp_cyc !== 3)
      begin n_fail++; $display("FAIL rci_zero: got wr=%0d data=%h cyc=%0d, expected 0 00000880 3", o_wr_cnt, o_rsp_data, o_rsp_cyc); end
    preload(12'h305, 32'h55);
    run_op(3'b001, 12'h305, 32'h1234_5678, 5'd2, 5'd0, 32'h0000_100C, 0, 0, 0);
    n_checks++;
    if (o_rd_en_cnt !== 0 || o_rsp_we !== 1'b0 || o_rsp_data !== 32'd0 || o_wr_data !== 32'h1234_5678)
      begin n_fail++; $display("FAIL rw_rd0: got rden=%0d we=%b data=%h wdata=%h, expected 0 0 0 12345678",
        o_rd_en_cnt, o_rsp_we, o_rsp_data, o_wr_data); end
  endtask

  task automatic test_illegal();
    preload(12'hC20, 32'h40);
    run_op(3'b001, 12'hC20, 32'h1, 5'd7, 5'd1, 32'h0000_2000, 0, 0, 0);
    n_checks++;
    if (o_exc_cnt !== 1 || o_exc_cyc !== 2 || o_exc_code !== 4'd2 || o_exc_tval !== 32'hC20 || o_exc_pc !== 32'h2000)
      begin n_fail++; $display("FAIL ro_exc: got cnt=%0d cyc=%0d code=%0d tval=%h pc=%h, expected 1 2 2 00000c20 00002000",
        o_exc_cnt, o_exc_cyc, o_exc_code, o_exc_tval, o_exc_pc); end
    n_checks++;
    if (o_wr_cnt !== 0 || o_rsp_cnt !== 0 || o_idle_cyc !== 3)
      begin n_fail++; $display("FAIL ro_noeffect: got wr=%0d rsp=%0d idle=%0d, expected 0 0 3", o_wr_cnt, o_rsp_cnt, o_idle_cyc); end
    run_op(3'b010, 12'hC20, 32'hFFFF_FFFF, 5'd0, 5'd6, 32'h0000_2004, 0, 0, 0);
    n_checks++;
    if (o_exc_cnt !== 0 || o_wr_cnt !== 0 || o_rsp_data !== 32'h40 || o_rsp_rd !== 5'd6)
      begin n_fail++; $display("FAIL ro_read: got exc=%0d wr=%0d data=%h rd=%0d, expected 0 0 00000040 6",
        o_exc_cnt, o_wr_cnt, o_rsp_data, o_rsp_rd); end
    run_op(3'b010, 12'h7FF, 32'h0, 5'd0, 5'd6, 32'h0000_2008, 0, 0, 0);
    n_checks++;
    if (o_exc_cnt !== 1 || o_exc_tval !== 32'h7FF || o_rsp_cnt !== 0)
      begin n_fail++; $display("FAIL unimpl_exc: got cnt=%0d tval=%h rsp=%0d, expected 1 000007ff 0", o_exc_cnt, o_exc_tval, o_rsp_cnt); end
  endtask

  task automatic test_flush();
    preload(12'h341, 32'h1234);
    run_op(3'b001, 12'h341, 32'hDEAD_BEE0, 5'd1, 5'd3, 32'h0000_3000, 0, 2, 0);
    n_checks++;
    if (o_wr_cnt !== 0 || o_rsp_cnt !== 0 || o_idle_cyc !== 3 || o_idle_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_write: got wr=%0d rsp=%0d idle=%0d ready=%b, expected 0 0 3 1",
        o_wr_cnt, o_rsp_cnt, o_idle_cyc, o_idle_ready); end
    run_op(3'b010, 12'h341, 32'h0, 5'd0, 5'd4, 32'h0000_3004, 0, 0, 0);
    n_checks++;
    if (o_rsp_data !== 32'h1234)
      begin n_fail++; $display("FAIL flush_effect: got mepc=%h, expected 00001234", o_rsp_data); end
  endtask

  task automatic test_backpressure_reset();
    preload(12'h300, 32'h0000_1888);
    run_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd7, 32'h0000_4000, 3, 0, 0);
    n_checks++;
    if (o_rsp_cnt !== 4 || o_rsp_unstable !== 1'b0 || o_ready_in_rsp !== 1'b0 || o_rsp_data !== 32'h1888 || o_idle_cyc !== 7)
      begin n_fail++; $display("FAIL rsp_hold: got cycles=%0d unstable=%b ready=%b data=%h idle=%0d, expected 4 0 0 00001888 7",
        o_rsp_cnt, o_rsp_unstable, o_ready_in_rsp, o_rsp_data, o_idle_cyc); end
    run_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd7, 32'h0000_4004, 20, 0, 4);
    n_checks++;
    if (o_rst_zero !== 1'b1 || o_idle_cyc !== 5 || o_idle_rsp !== 1'b0 || o_idle_ready !== 1'b1)
      begin n_fail++; $display("FAIL rsp_reset: got zero=%b idle=%0d rsp=%b ready=%b, expected 1 5 0 1",
        o_rst_zero, o_idle_cyc, o_idle_rsp, o_idle_ready); end
  endtask

  task automatic test_random(input int n_ops);
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] rs1d, pc;
    logic [4:0]  idx, rd;
    int          sel, bad;
    foreach (impl_list[i]) preload(impl_list[i], $urandom);
    foreach (unimpl_list[i]) preload(unimpl_list[i], $urandom);
    for (int t = 0; t < n_ops; t++) begin
      op   = 3'($urandom_range(0, 7));
      sel  = int'($urandom_range(0, 19));
      addr = (sel < 17) ? impl_list[sel] : unimpl_list[sel - 17];
      rs1d = $urandom;
      idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pc   = $urandom & 32'hFFFF_FFFC;
      model(op, addr, rs1d, idx, rd);
      run_op(op, addr, rs1d, idx, rd, pc, int'($urandom_range(0, 2)), 0, 0);
      n_checks++;
      if (o_timeout !== 1'b0 || o_exc_cnt !== (m_ill ? 1 : 0) || o_rd_en_cnt !== (m_rdn ? 1 : 0))
        begin n_fail++; $display("FAIL rnd_ctrl op=%0d addr=%h: got to=%b exc=%0d rden=%0d, expected 0 %0d %0d",
          op, addr, o_timeout, o_exc_cnt, o_rd_en_cnt, m_ill, m_rdn); end
      n_checks++;
      if (o_wr_cnt !== ((!m_ill && m_wr) ? 1 : 0) || (o_wr_cnt == 1 && (o_wr_cyc !== 2 || o_wr_addr !== addr || o_wr_data !== m_new)))
        begin n_fail++; $display("FAIL rnd_write op=%0d addr=%h: got cnt=%0d cyc=%0d addr=%h data=%h, expected cnt=%0d data=%h",
          op, addr, o_wr_cnt, o_wr_cyc, o_wr_addr, o_wr_data, (!m_ill && m_wr), m_new); end
      n_checks++;
      if (m_ill) begin
        if (o_rsp_cnt !== 0 || o_exc_cyc !== 2 || o_exc_code !== 4'd2 || o_exc_pc !== pc || o_exc_tval !== {20'd0, addr})
          begin n_fail++; $display("FAIL rnd_exc op=%0d addr=%h: got rsp=%0d cyc=%0d code=%0d pc=%h tval=%h, expected 0 2 2 %h %h",
            op, addr, o_rsp_cnt, o_exc_cyc, o_exc_code, o_exc_pc, o_exc_tval, pc, {20'd0, addr}); end
      end else begin
        if (o_rsp_cyc !== 3 || o_rsp_rd !== rd || o_rsp_we !== (rd != 5'd0) || o_rsp_data !== m_old)
          begin n_fail++; $display("FAIL rnd_rsp op=%0d addr=%h: got cyc=%0d rd=%0d we=%b data=%h, expected 3 %0d %b %h",
            op, addr, o_rsp_cyc, o_rsp_rd, o_rsp_we, o_rsp_data, rd, (rd != 5'd0), m_old); end
        if (m_wr) ref_csr[addr] = m_new;
      end
    end
    bad = 0;
    foreach (impl_list[i]) if (csr_file[impl_list[i]] !== ref_csr[impl_list[i]]) bad++;
    n_checks++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL rnd_final_state: got %0d CSRs differing from model, expected 0", bad); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_rs1_data = '0;
    bus.req_rs1_idx = '0; bus.req_rd = '0; bus.req_pc = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin csr_file[i] = '0; ref_csr[i] = '0; end
    test_reset();
    test_csrrw();
    test_csrrs();
    test_no_side_effect();
    test_illegal();
    test_flush();
    test_backpressure_reset();
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
Execute stage for Zicsr instructions (CSRRW/RS/RC and immediate forms). It accepts a decoded CSR request and performs the read-modify-write sequence on the CSR register file's read and write ports. It then returns the old value for rd writeback, or raises an illegal-instruction trap toward the trap logic. The block sits between decode/issue and the CSR register file.

Parameters:
ADDR_WIDTH, 12, CSR address width
DATA_WIDTH, 32, CSR data width
REG_IDX_WIDTH, 5, GPR index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
req_addr  in  ADDR_WIDTH  CSR address
req_rs1_data  in  DATA_WIDTH  rs1 value
req_rs1_idx  in  REG_IDX_WIDTH  rs1 index, or zimm for I-forms
req_rd  in  REG_IDX_WIDTH  destination register
req_pc  in  32  instruction PC
flush  in  1  trap/redirect; kills in-flight op
csr_read_en  out  1  CSR file read strobe
csr_read_addr  out  ADDR_WIDTH  CSR file read address
csr_read_data  in  DATA_WIDTH  CSR file read data (combinational)
csr_write_en  out  1  CSR file write strobe
csr_write_addr  out  ADDR_WIDTH  CSR file write address
csr_write_data  out  DATA_WIDTH  CSR file write data
rsp_valid  out  1  writeback valid
rsp_ready  in  1  writeback accepts
rsp_rd  out  REG_IDX_WIDTH  writeback register
rsp_we  out  1  1 = write GPR (rd != 0)
rsp_data  out  DATA_WIDTH  old CSR value
exc_valid  out  1  one-cycle illegal-instruction pulse
exc_code  out  4  fixed 4'd2 (illegal instruction)
exc_pc  out  32  faulting PC
exc_tval  out  32  zero-extended CSR address
busy  out  1  state != IDLE

Behaviour:
- Single clock. Reset is synchronous, active-high. While rst is high, state = IDLE and every output is 0, including req_ready.
- States: IDLE, READ, WRITE, RESP, EXC.
- req_ready = (state==IDLE) & ~flush & ~rst. On acceptance, op/addr/src/rd/pc are registered and the FSM moves to READ.
- src = I-form ? {27'b0, req_rs1_idx} : req_rs1_data.
- write_intent = RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
- read_intent = 0 only for RW/RWI with rd == 0; otherwise 1.
- Illegal when any of these holds: op is 000 or 100; address not implemented (package function); write_intent with addr[11:10] == 2'b11.
- READ:
  - csr_read_en = read_intent, csr_read_addr = addr.
  - old = read_intent ? csr_read_data : 0, registered.
  - new value: RW = src; RS = old | src; RC = old & ~src. Computed and registered.
  - Next state is EXC if illegal, else WRITE.
- WRITE: csr_write_en = write_intent, with address and data from registers, for exactly one cycle. Next state RESP.
- RESP: rsp_valid = 1, rsp_we = (rd != 0), rsp_data = old. All three hold stable until rsp_ready, then IDLE. No new request is accepted until the IDLE cycle.
- EXC: exc_valid pulse for one cycle with code, pc and tval. No CSR write, no response. Next state IDLE.
- Latency: accept at cycle N, read at N+1, write at N+2, rsp_valid at N+3. Throughput is at most one op per 4 cycles.
- flush has highest priority. In any state, flush forces IDLE on the next edge.
  - csr_write_en is gated by ~flush in the same cycle.
  - rsp_valid and exc_valid are gated by ~flush.
  - A killed op leaves no architectural effect.
- Reset mid-operation: next cycle is IDLE and all outputs are 0. A pending write is dropped.
- Implemented addresses: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip, 0xB00 mcycle, 0xC01 time, 0xC81 timeh, 0x008 vstart, 0x009 vxsat, 0x00A vxrm, 0x00F vcsr, 0xC20 vl, 0xC21 vtype, 0xC22 vlenb.

Decomposition:
- Shared package csr_pkg holds:
  - the CSR address localparams (matching the existing defines);
  - a csr_op_e enum for funct3;
  - a csr_state_e FSM enum;
  - a csr_is_implemented(addr) function;
  - a csr_is_readonly(addr) function;
  - EXC_ILLEGAL_INSTR = 4'd2.
- One sub-module is natural: csr_alu (combinational RW/RS/RC merge of old and src). The FSM stays in the top module.

Test Plan:
1. CSRRW 0x305, rs1_data 0x8000_0100, rd=5, old 0 → csr_write_en at N+2 with addr 0x305, data 0x8000_0100; rsp at N+3 with rd 5, we 1, data 0.
2. CSRRS 0x300, rs1_idx 3, rs1_data 0x8, old 0x1800 → write data 0x1808; rsp_data 0x1800.
3. CSRRCI 0x304, zimm 0, old 0x880 → no csr_write_en; rsp_data 0x880. Then CSRRW 0x305 with rd=0 → csr_read_en stays 0 and rsp_we is 0.
4. CSRRW 0xC20 → exc_valid pulse at N+2 with code 2, tval 0xC20, pc = req_pc; no write and no rsp. CSRRS 0xC20 with rs1=x0 → legal, returns the vl value. Address 0x7FF → exception.
5. flush asserted in the WRITE cycle → csr_write_en stays 0, no rsp, IDLE next cycle, and req_ready = 1 one cycle later.
6. rsp_ready held low for 3 cycles → rsp fields stable and req_ready 0 throughout. Then assert rst in RESP → rsp_valid is 0 next cycle and state is IDLE.
